edge2en_multi: RTL and testbench
================================

// Module: edge2en_multi
// PURPOSE
//  CH-channel edge-to-enable converter: synchronises async inputs, debounces each channel,
//  emits one-cycle rising/falling pulses, a per-channel mode-selected event, sticky pending
//  flags with clear, and an OR'd interrupt. Sits between raw pins/buttons and control FSMs.
// PARAMETERS
//  CH          4   number of independent channels (>=1)
//  SYNC_STAGES 2   synchroniser flops per channel (>=2)
//  FILTER_CNT  4   consecutive differing cycles before the debounced level changes (>=1; 1 = no filtering)
// PORTS
//  clk_in        in   1       single clock; all state updates on its rising edge
//  rst_in        in   1       synchronous, active-high reset
//  edge_in       in   CH      asynchronous raw inputs
//  mode_in       in   2*CH    per-channel event select, ch i = [2i+1:2i]; edge_mode_t
//  clr_in        in   CH      per-channel sticky-pending clear, level-sampled
//  level_out     out  CH      debounced level
//  rising_out    out  CH      1-cycle pulse on debounced 0->1
//  falling_out   out  CH      1-cycle pulse on debounced 1->0
//  event_out     out  CH      mode-selected pulse (rising/falling/either/none)
//  pend_out      out  CH      sticky event flag
//  irq_out       out  1       |pend_out
// BEHAVIOUR
//  - Reset (rst_in=1 at a clk_in edge): sync chain, counters, level, edge regs, pend all 0;
//    every output 0 the cycle after. rst_in dominates every other input.
//  - Sync: edge_in[i] shifts through SYNC_STAGES flops; last stage = sync[i].
//  - Debounce per channel: cnt width $clog2(FILTER_CNT+1).
//      sync==level             -> cnt<=0
//      sync!=level, cnt<F-1    -> cnt<=cnt+1
//      sync!=level, cnt==F-1   -> level<=sync, cnt<=0
//    Any one-cycle return to sync==level restarts the count (glitch of < F cycles rejected).
//  - Edge: level_d <= level; rising_out/falling_out/event_out are registered from
//    level & ~level_d / ~level & level_d; each exactly 1 cycle wide, never both high.
//  - Latency: input stable at new value from sampling edge E1 -> pulse high after edge
//    E(SYNC_STAGES+FILTER_CNT+1), low after the next edge. Defaults: 7th edge.
//  - mode_in: 2'b00 NONE, 2'b01 RISE, 2'b10 FALL, 2'b11 BOTH; sampled in the same cycle
//    the event is formed; changing mode does not create or drop a pending flag.
//  - pend[i]: set on event_out-forming cycle, cleared by clr_in[i]; set and clear in the
//    same cycle -> set wins (no event lost). Clearing an already-clear flag is a no-op.
//  - irq_out: combinational OR of pend registers (glitch-free, from flops only).
//  - Input high through and after reset: level starts 0, so one rising pulse is produced
//    after the full latency once rst_in drops (intended: no edge lost across reset).
//  - Reset mid-debounce or mid-pulse: count and pulse abandoned; no pulse after reset
//    unless the post-reset sequence produces one.
//  - Channels fully independent; simultaneous events on all CH handled in one cycle.
// STRUCTURE
//  - Package edge2en_pkg: typedef enum logic [1:0] edge_mode_t {EM_NONE,EM_RISE,EM_FALL,
//    EM_BOTH}; function cnt_width(int f) returning $clog2(f+1).
//  - Sub-module edge2en_ch: one channel (sync chain, debounce counter, level, rise/fall
//    regs); instantiated CH times via generate. Top holds mode select, pend, irq.
// TESTING (CH=4, SYNC_STAGES=2, FILTER_CNT=4)
//  1 rst_in=1 3 cycles, edge_in=4'hF -> all outputs 0 during reset; after release rising_out=4'hF
//    exactly once at edge 7, level_out=4'hF thereafter.
//  2 ch0 glitch: edge_in[0] high 3 cycles then low -> no level change, no pulse; high 4+
//    cycles -> rising_out[0] single pulse at edge 7.
//  3 mode_in=8'b11_10_01_00, toggle all channels 0->1->0 -> event_out: ch0 none, ch1 rise
//    only, ch2 fall only, ch3 both; pend_out=4'b1110, irq_out=1.
//  4 clr_in[1]=1 same cycle as new ch1 event -> pend_out[1] stays 1; clr_in[1] alone next
//    cycle -> pend_out[1]=0; irq_out falls when pend_out==0.
//  5 rst_in pulsed for 1 cycle during ch2 count (cnt=2) -> no pulse; count restarts from 0.
//  6 random edge_in with bounces < 4 cycles vs. reference model -> exact cycle match on
//    all outputs; rising_out & falling_out never both high.

Source files
------------

// File: rtl/edge2en_pkg.sv
// Shared types and helpers for the multi-channel edge-to-enable converter.
// Provides the per-channel event mode encoding, counter sizing and event select.
package edge2en_pkg;

   typedef enum logic [1:0] {
      EM_NONE = 2'b00,
      EM_RISE = 2'b01,
      EM_FALL = 2'b10,
      EM_BOTH = 2'b11
   } edge_mode_t;

   // Debounce counter width able to hold 0..f.
   function automatic int cnt_width(input int f);
      return $clog2(f + 1);
   endfunction

   // Pick the event for one channel from its rise/fall strobes.
   function automatic logic sel_event(
      input edge_mode_t mode,
      input logic       rise,
      input logic       fall
   );
      logic ev;
      ev = 1'b0;
      unique case (mode)
         EM_NONE: ev = 1'b0;
         EM_RISE: ev = rise;
         EM_FALL: ev = fall;
         EM_BOTH: ev = rise | fall;
         default: ev = 1'b0;
      endcase
      return ev;
   endfunction

endpackage

// File: rtl/edge2en_ch.sv
// One channel: synchroniser chain, debounce counter, debounced level and
// registered one-cycle rise/fall pulses.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   raw               asynchronous input pin
//   level             debounced level
//   rise, fall        registered one-cycle edge pulses
//   rise_nxt, fall_nxt  values rise/fall take at the next edge
module edge2en_ch
   import edge2en_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_CNT  = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic rise,
   output logic fall,
   output logic rise_nxt,
   output logic fall_nxt
);

   localparam int CW = cnt_width(FILTER_CNT);
   localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CNT - 1);

   logic [SYNC_STAGES-1:0] sr;
   logic                   sync;
   logic [CW-1:0]          cnt;
   logic                   level_d;

   assign sync = sr[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         sr <= '0;
      end else begin
         sr <= {sr[SYNC_STAGES-2:0], raw};
      end
   end

   // Level only moves after FILTER_CNT consecutive differing samples;
   // any agreeing sample restarts the count.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= '0;
         level <= 1'b0;
      end else if (sync == level) begin
         cnt <= '0;
      end else if (cnt < CNT_LAST) begin
         cnt <= cnt + 1'b1;
      end else begin
         cnt   <= '0;
         level <= sync;
      end
   end

   assign rise_nxt = level & ~level_d;
   assign fall_nxt = ~level & level_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         level_d <= 1'b0;
         rise    <= 1'b0;
         fall    <= 1'b0;
      end else begin
         level_d <= level;
         rise    <= rise_nxt;
         fall    <= fall_nxt;
      end
   end

endmodule

// File: rtl/edge2en_multi.sv
// CH-channel edge-to-enable converter with mode-selected events,
// sticky pending flags and an OR'd interrupt.
// Ports:
//   clk_in, rst_in     clock and synchronous active-high reset
//   edge_in[CH]        asynchronous raw inputs
//   mode_in[2*CH]      per-channel edge_mode_t, ch i at [2i+1:2i]
//   clr_in[CH]         per-channel pending clear (set wins)
//   level_out, rising_out, falling_out, event_out, pend_out [CH]
//   irq_out            OR of pending flags
module edge2en_multi
   import edge2en_pkg::*;
#(
   parameter int CH          = 4,
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_CNT  = 4
) (
   input  logic            clk_in,
   input  logic            rst_in,
   input  logic [CH-1:0]   edge_in,
   input  logic [2*CH-1:0] mode_in,
   input  logic [CH-1:0]   clr_in,
   output logic [CH-1:0]   level_out,
   output logic [CH-1:0]   rising_out,
   output logic [CH-1:0]   falling_out,
   output logic [CH-1:0]   event_out,
   output logic [CH-1:0]   pend_out,
   output logic            irq_out
);

   logic [CH-1:0] rise_nxt;
   logic [CH-1:0] fall_nxt;
   logic [CH-1:0] ev_nxt;
   logic [CH-1:0] pend;

   for (genvar i = 0; i < CH; i++) begin : g_ch
      edge2en_ch #(
         .SYNC_STAGES (SYNC_STAGES),
         .FILTER_CNT  (FILTER_CNT)
      ) u_ch (
         .clk      (clk_in),
         .rst      (rst_in),
         .raw      (edge_in[i]),
         .level    (level_out[i]),
         .rise     (rising_out[i]),
         .fall     (falling_out[i]),
         .rise_nxt (rise_nxt[i]),
         .fall_nxt (fall_nxt[i])
      );
   end

   // Events are formed alongside the rise/fall registers so the mode
   // applies in the same cycle the pulse is created.
   always_comb begin
      ev_nxt = '0;
      for (int i = 0; i < CH; i++) begin
         ev_nxt[i] = sel_event(edge_mode_t'(mode_in[2*i +: 2]),
                               rise_nxt[i], fall_nxt[i]);
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         event_out <= '0;
         pend      <= '0;
      end else begin
         event_out <= ev_nxt;
         pend      <= (pend & ~clr_in) | ev_nxt;
      end
   end

   assign pend_out = pend;
   assign irq_out  = |pend;

endmodule

// File: tb/tb_edge2en_multi.sv
// Directed and model-checked bench for edge2en_multi (CH=4, 2 sync, filter 4).
// Ports: none.
module tb_edge2en_multi;

   logic       clk_in;
   logic       rst_in;
   logic [3:0] edge_in;
   logic [7:0] mode_in;
   logic [3:0] clr_in;
   logic [3:0] level_out;
   logic [3:0] rising_out;
   logic [3:0] falling_out;
   logic [3:0] event_out;
   logic [3:0] pend_out;
   logic       irq_out;

   int checks;
   int failures;

   edge2en_multi #(
      .CH          (4),
      .SYNC_STAGES (2),
      .FILTER_CNT  (4)
   ) dut (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .edge_in     (edge_in),
      .mode_in     (mode_in),
      .clr_in      (clr_in),
      .level_out   (level_out),
      .rising_out  (rising_out),
      .falling_out (falling_out),
      .event_out   (event_out),
      .pend_out    (pend_out),
      .irq_out     (irq_out)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk_in);
         #1;
      end
   endtask

   task automatic test_reset;
      rst_in  = 1'b1;
      edge_in = 4'hF;
      mode_in = 8'h00;
      clr_in  = 4'h0;
      for (int i = 0; i < 3; i++) begin
         tick(1);
         checks++;
         if ({level_out, rising_out, falling_out, event_out, pend_out, irq_out} !== 21'h0) begin
            failures++;
            $display("FAIL reset_outs cyc=%0d got=%h exp=0", i,
                     {level_out, rising_out, falling_out, event_out, pend_out, irq_out});
         end
      end
      rst_in = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         tick(1);
         checks++;
         if (rising_out !== 4'h0) begin
            failures++;
            $display("FAIL reset_early_rise edge=%0d got=%h exp=0", i, rising_out);
         end
      end
      tick(1);
      checks++;
      if (rising_out !== 4'hF) begin
         failures++;
         $display("FAIL reset_rise_e7 got=%h exp=f", rising_out);
      end
      tick(1);
      checks++;
      if (rising_out !== 4'h0 || level_out !== 4'hF) begin
         failures++;
         $display("FAIL reset_after got rise=%h lvl=%h exp rise=0 lvl=f",
                  rising_out, level_out);
      end
   endtask

   task automatic test_glitch;
      int pulses;
      edge_in = 4'h0;
      tick(10);
      checks++;
      if (level_out !== 4'h0) begin
         failures++;
         $display("FAIL glitch_prep_lvl got=%h exp=0", level_out);
      end
      pulses = 0;
      edge_in[0] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick(1);
         pulses += int'(rising_out[0]) + int'(level_out[0]);
      end
      edge_in[0] = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         pulses += int'(rising_out[0]) + int'(level_out[0]);
      end
      checks++;
      if (pulses !== 0) begin
         failures++;
         $display("FAIL glitch_reject got=%0d exp=0", pulses);
      end
      edge_in[0] = 1'b1;
      tick(6);
      checks++;
      if (rising_out[0] !== 1'b0) begin
         failures++;
         $display("FAIL glitch_e6 got=%b exp=0", rising_out[0]);
      end
      tick(1);
      checks++;
      if (rising_out !== 4'h1) begin
         failures++;
         $display("FAIL glitch_e7 got=%h exp=1", rising_out);
      end
      tick(1);
      checks++;
      if (rising_out !== 4'h0 || level_out !== 4'h1) begin
         failures++;
         $display("FAIL glitch_e8 got rise=%h lvl=%h exp rise=0 lvl=1",
                  rising_out, level_out);
      end
   endtask

   task automatic test_modes;
      edge_in = 4'h0;
      clr_in  = 4'hF;
      tick(10);
      clr_in  = 4'h0;
      mode_in = 8'b11_10_01_00;
      tick(1);
      checks++;
      if (pend_out !== 4'h0 || irq_out !== 1'b0) begin
         failures++;
         $display("FAIL modes_prep got pend=%h irq=%b exp 0", pend_out, irq_out);
      end
      edge_in = 4'hF;
      tick(7);
      checks++;
      if (event_out !== 4'b1010 || rising_out !== 4'hF) begin
         failures++;
         $display("FAIL modes_rise got ev=%h rise=%h exp ev=a rise=f",
                  event_out, rising_out);
      end
      tick(1);
      checks++;
      if (event_out !== 4'h0 || pend_out !== 4'b1010) begin
         failures++;
         $display("FAIL modes_rise_pend got ev=%h pend=%h exp ev=0 pend=a",
                  event_out, pend_out);
      end
      edge_in = 4'h0;
      tick(7);
      checks++;
      if (event_out !== 4'b1100 || falling_out !== 4'hF || rising_out !== 4'h0) begin
         failures++;
         $display("FAIL modes_fall got ev=%h fall=%h rise=%h exp ev=c fall=f rise=0",
                  event_out, falling_out, rising_out);
      end
      tick(1);
      checks++;
      if (pend_out !== 4'b1110 || irq_out !== 1'b1) begin
         failures++;
         $display("FAIL modes_pend got pend=%h irq=%b exp pend=e irq=1",
                  pend_out, irq_out);
      end
   endtask

   task automatic test_clear;
      edge_in[1] = 1'b1;
      tick(6);
      clr_in = 4'b0010;
      tick(1);
      checks++;
      if (event_out[1] !== 1'b1 || pend_out !== 4'b1110) begin
         failures++;
         $display("FAIL clr_set_wins got ev=%h pend=%h exp ev[1]=1 pend=e",
                  event_out, pend_out);
      end
      tick(1);
      checks++;
      if (pend_out !== 4'b1100 || irq_out !== 1'b1) begin
         failures++;
         $display("FAIL clr_ch1 got pend=%h irq=%b exp pend=c irq=1",
                  pend_out, irq_out);
      end
      clr_in = 4'b1100;
      tick(1);
      checks++;
      if (pend_out !== 4'h0 || irq_out !== 1'b0) begin
         failures++;
         $display("FAIL clr_all got pend=%h irq=%b exp pend=0 irq=0",
                  pend_out, irq_out);
      end
      clr_in = 4'hF;
      tick(1);
      clr_in = 4'h0;
      checks++;
      if (pend_out !== 4'h0 || irq_out !== 1'b0) begin
         failures++;
         $display("FAIL clr_noop got pend=%h irq=%b exp 0", pend_out, irq_out);
      end
   endtask

   task automatic test_reset_mid;
      int early;
      edge_in = 4'b0110;
      tick(4);
      rst_in = 1'b1;
      tick(1);
      rst_in = 1'b0;
      checks++;
      if ({level_out, rising_out, falling_out, event_out, pend_out, irq_out} !== 21'h0) begin
         failures++;
         $display("FAIL rstmid_outs got=%h exp=0",
                  {level_out, rising_out, falling_out, event_out, pend_out, irq_out});
      end
      early = 0;
      for (int i = 0; i < 6; i++) begin
         tick(1);
         early += int'(rising_out != 4'h0) + int'(event_out != 4'h0);
      end
      checks++;
      if (early !== 0) begin
         failures++;
         $display("FAIL rstmid_early got=%0d exp=0", early);
      end
      tick(1);
      checks++;
      if (rising_out !== 4'b0110 || event_out !== 4'b0010) begin
         failures++;
         $display("FAIL rstmid_e7 got rise=%h ev=%h exp rise=6 ev=2",
                  rising_out, event_out);
      end
   endtask

   task automatic test_random;
      logic [1:0] m_sr [4];
      int         m_cnt [4];
      logic [3:0] m_lvl, m_lvld, m_rise, m_fall, m_ev, m_pend;
      logic [3:0] n_lvl, n_lvld, n_rise, n_fall, n_ev, n_pend;
      logic       s, rn, fn;
      logic [1:0] md;
      int         bad_both;
      rst_in  = 1'b1;
      edge_in = 4'h0;
      clr_in  = 4'h0;
      tick(2);
      rst_in  = 1'b0;
      for (int c = 0; c < 4; c++) begin
         m_sr[c]  = 2'b00;
         m_cnt[c] = 0;
      end
      m_lvl = 0; m_lvld = 0; m_rise = 0; m_fall = 0; m_ev = 0; m_pend = 0;
      bad_both = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         for (int c = 0; c < 4; c++) begin
            if ($urandom_range(5) == 0) edge_in[c] = ~edge_in[c];
         end
         if (cyc % 50 == 0) mode_in = 8'($urandom);
         clr_in = ($urandom_range(7) == 0) ? 4'($urandom) : 4'h0;
         tick(1);
         n_lvl = m_lvl;
         for (int c = 0; c < 4; c++) begin
            s  = m_sr[c][1];
            rn = m_lvl[c] & ~m_lvld[c];
            fn = ~m_lvl[c] & m_lvld[c];
            md = mode_in[2*c +: 2];
            n_rise[c] = rn;
            n_fall[c] = fn;
            n_ev[c]   = (md[0] & rn) | (md[1] & fn);
            n_pend[c] = (m_pend[c] & ~clr_in[c]) | n_ev[c];
            n_lvld[c] = m_lvl[c];
            if (s == m_lvl[c]) begin
               m_cnt[c] = 0;
            end else if (m_cnt[c] < 3) begin
               m_cnt[c] = m_cnt[c] + 1;
            end else begin
               m_cnt[c] = 0;
               n_lvl[c] = s;
            end
            m_sr[c] = {m_sr[c][0], edge_in[c]};
         end
         m_lvl = n_lvl; m_lvld = n_lvld; m_rise = n_rise;
         m_fall = n_fall; m_ev = n_ev; m_pend = n_pend;
         checks++;
         if ({level_out, rising_out, falling_out, event_out, pend_out, irq_out} !==
             {m_lvl, m_rise, m_fall, m_ev, m_pend, |m_pend}) begin
            failures++;
            $display("FAIL random cyc=%0d got=%h exp=%h", cyc,
                     {level_out, rising_out, falling_out, event_out, pend_out, irq_out},
                     {m_lvl, m_rise, m_fall, m_ev, m_pend, |m_pend});
         end
         if ((rising_out & falling_out) != 4'h0) bad_both++;
      end
      checks++;
      if (bad_both !== 0) begin
         failures++;
         $display("FAIL rise_fall_both got=%0d exp=0", bad_both);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_in   = 1'b1;
      edge_in  = 4'h0;
      mode_in  = 8'h00;
      clr_in   = 4'h0;
      #1;
      test_reset();
      test_glitch();
      test_modes();
      test_clear();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
